// File: rtl/riscv_dcache_if.sv
// riscv_dcache_if: core-side and memory-side signal bundle for riscv_dcache.
// Core side: REQ/WE/ADDR/BE/WDATA in, RDATA/STALL out.
// Memory side: D_MEM_CSN/WEN/ADDR/DOUT out, D_MEM_DI in.
// The slave modport is the cache. The master modport is the core plus memory environment.
interface riscv_dcache_if;
  logic         REQ;
  logic         WE;
  logic [13:0]  ADDR;
  logic [3:0]   BE;
  logic [31:0]  WDATA;
  logic [31:0]  RDATA;
  logic         STALL;
  logic         D_MEM_CSN;
  logic         D_MEM_WEN;
  logic [9:0]   D_MEM_ADDR;
  logic [127:0] D_MEM_DOUT;
  logic [127:0] D_MEM_DI;
  modport master (
    output REQ, WE, ADDR, BE, WDATA, D_MEM_DI,
    input  RDATA, STALL, D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_DOUT
  );
  modport slave (
    input  REQ, WE, ADDR, BE, WDATA, D_MEM_DI,
    output RDATA, STALL, D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_DOUT
  );
endinterface

// File: rtl/riscv_dcache.sv
// riscv_dcache: direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Ports: CLK, RSTn (synchronous, active-low), bus (riscv_dcache_if.slave) carrying the
// core word access (REQ/WE/ADDR/BE/WDATA -> RDATA/STALL) and the line-wide memory
// transfer bus (D_MEM_CSN/WEN/ADDR/DOUT -> D_MEM_DI).
// Optional: define RISCV_DCACHE_STAT_EN to add HIT_CNT[31:0] and MISS_CNT[31:0] outputs.
module riscv_dcache #(
  parameter int NUM_LINES = 8,
  parameter int MEM_LAT   = 4
) (
  input  logic CLK,
  input  logic RSTn,
  riscv_dcache_if.slave bus
`ifdef RISCV_DCACHE_STAT_EN
  ,
  output logic [31:0] HIT_CNT,
  output logic [31:0] MISS_CNT
`endif
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 10 - IDX_W;

  typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

  state_t                              state_q, state_d;
  logic [15:0]                         cnt_q, cnt_d;
  logic [NUM_LINES-1:0]                valid_q, valid_d, dirty_q, dirty_d;
  logic [NUM_LINES-1:0][TAG_W-1:0]     tag_q, tag_d;
  logic [NUM_LINES-1:0][127:0]         data_q, data_d;
  logic [9:0]                          miss_line_q, miss_line_d;
  logic [TAG_W-1:0]                    victim_tag_q, victim_tag_d;
  logic                                mem_csn_q, mem_csn_d, mem_wen_q, mem_wen_d;
  logic [9:0]                          mem_addr_q, mem_addr_d;

  logic [IDX_W-1:0] idx, m_idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       word;
  logic             hit, last;
  logic [127:0]     merged;
  logic             unused_addr;

  assign idx         = bus.ADDR[3+IDX_W:4];
  assign tag         = bus.ADDR[13:4+IDX_W];
  assign word        = bus.ADDR[3:2];
  assign m_idx       = miss_line_q[IDX_W-1:0];
  assign hit         = bus.REQ & valid_q[idx] & (tag_q[idx] == tag);
  assign last        = cnt_q == 16'(MEM_LAT - 1);
  assign unused_addr = ^bus.ADDR[1:0];

  assign bus.STALL      = RSTn & ((state_q != IDLE) | (bus.REQ & ~hit));
  assign bus.RDATA      = (RSTn & (state_q == IDLE) & hit) ? data_q[idx][32*word +: 32] : 32'd0;
  assign bus.D_MEM_CSN  = mem_csn_q;
  assign bus.D_MEM_WEN  = mem_wen_q;
  assign bus.D_MEM_ADDR = mem_addr_q;
  // The victim line cannot change while in WB, so this decode is stable for the whole transfer.
  assign bus.D_MEM_DOUT = (state_q == WB) ? data_q[m_idx] : 128'd0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    miss_line_d  = miss_line_q;
    victim_tag_d = victim_tag_q;
    merged       = data_q[idx];
    for (int b = 0; b < 4; b++)
      if (bus.BE[b]) merged[32*word + 8*b +: 8] = bus.WDATA[8*b +: 8];
    if (state_q == IDLE) begin
      if (hit & bus.WE) begin
        data_d[idx]  = merged;
        dirty_d[idx] = 1'b1;
      end else if (bus.REQ & ~hit) begin
        miss_line_d  = bus.ADDR[13:4];
        victim_tag_d = tag_q[idx];
        cnt_d        = 16'd0;
        state_d      = (valid_q[idx] & dirty_q[idx]) ? WB : ALLOC;
      end
    end else if (state_q == WB) begin
      cnt_d = last ? 16'd0 : cnt_q + 16'd1;
      if (last) begin
        dirty_d[m_idx] = 1'b0;
        state_d        = ALLOC;
      end
    end else if (state_q == ALLOC) begin
      cnt_d = last ? 16'd0 : cnt_q + 16'd1;
      if (last) begin
        data_d[m_idx]  = bus.D_MEM_DI;
        valid_d[m_idx] = 1'b1;
        dirty_d[m_idx] = 1'b0;
        tag_d[m_idx]   = miss_line_q[9:IDX_W];
        state_d        = IDLE;
      end
    end else begin
      state_d = IDLE;
    end
    // Memory strobes are registered from the next state so they never follow core inputs.
    mem_csn_d  = ~((state_d == WB) | (state_d == ALLOC));
    mem_wen_d  = state_d != WB;
    mem_addr_d = (state_d == WB) ? {victim_tag_d, miss_line_d[IDX_W-1:0]} :
                 (state_d == ALLOC) ? miss_line_d : 10'd0;
  end

  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
    if (!RSTn) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_line_q  <= 10'd0;
      victim_tag_q <= '0;
      mem_csn_q    <= 1'b1;
      mem_wen_q    <= 1'b1;
      mem_addr_q   <= 10'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      miss_line_q  <= miss_line_d;
      victim_tag_q <= victim_tag_d;
      mem_csn_q    <= mem_csn_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

`ifdef RISCV_DCACHE_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        fill_q, fill_d;

  // fill_q marks the IDLE cycle right after a refill, where the held access hits but was already counted as a miss.
  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'((state_q == IDLE) & hit & ~fill_q);
    miss_cnt_d = miss_cnt_q + 32'((state_q == IDLE) & bus.REQ & ~hit);
    fill_d     = (state_q == ALLOC) & last;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
      fill_q     <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      fill_q     <= fill_d;
    end
  end

  assign HIT_CNT  = hit_cnt_q;
  assign MISS_CNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_riscv_dcache.sv
// tb_riscv_dcache: directed self-checking bench for riscv_dcache (NUM_LINES=8, MEM_LAT=4).
module tb_riscv_dcache;
  logic clk = 1'b0;
  logic rstn;
  int   n_chk = 0;
  int   n_fail = 0;
  int   stalls, alloc_n, wb_n, csn_low;
  logic [9:0]   alloc_addr, wb_addr;
  logic [31:0]  rd, wb_w2;
  logic         csn_at_done;
  logic [127:0] mem [1024];
`ifdef RISCV_DCACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  riscv_dcache_if bus ();

  riscv_dcache #(.NUM_LINES(8), .MEM_LAT(4)) dut (
    .CLK(clk),
    .RSTn(rstn),
    .bus(bus)
`ifdef RISCV_DCACHE_STAT_EN
    ,
    .HIT_CNT(hit_cnt),
    .MISS_CNT(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_line(input int a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'hA5000000 | 32'(k << 16) | 32'(a);
    return r;
  endfunction

  initial for (int i = 0; i < 1024; i++) mem[i] = mk_line(i);

  always @(posedge clk)
    if (!bus.D_MEM_CSN && !bus.D_MEM_WEN) mem[bus.D_MEM_ADDR] <= bus.D_MEM_DOUT;

  assign bus.D_MEM_DI = mem[bus.D_MEM_ADDR];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One core access: holds the request until STALL drops (bounded), logging memory activity.
  task automatic acc(input logic we, input logic [13:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus.REQ = 1'b1; bus.WE = we; bus.ADDR = a; bus.BE = be; bus.WDATA = wd;
    stalls = 0; alloc_n = 0; wb_n = 0; alloc_addr = '0; wb_addr = '0; wb_w2 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.STALL) break;
      stalls++;
      if (!bus.D_MEM_CSN && bus.D_MEM_WEN) begin alloc_n++; alloc_addr = bus.D_MEM_ADDR; end
      if (!bus.D_MEM_CSN && !bus.D_MEM_WEN) begin wb_n++; wb_addr = bus.D_MEM_ADDR; wb_w2 = bus.D_MEM_DOUT[95:64]; end
      @(posedge clk); #1;
    end
    rd = bus.RDATA;
    csn_at_done = bus.D_MEM_CSN;
    @(posedge clk); #1;
    bus.REQ = 1'b0; bus.WE = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.REQ = 1'b1; bus.WE = 1'b0; bus.ADDR = 14'h0100; bus.BE = 4'h0; bus.WDATA = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 128'(bus.STALL), 128'd0);
    check("rst_rdata", 128'(bus.RDATA), 128'd0);
    check("rst_csn", 128'(bus.D_MEM_CSN), 128'd1);
    check("rst_maddr", 128'(bus.D_MEM_ADDR), 128'd0);
    bus.REQ = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    acc(1'b0, 14'h0100, 4'h0, 32'h0);
    check("miss_stalls", 128'(stalls), 128'd5);
    check("miss_alloc_n", 128'(alloc_n), 128'd4);
    check("miss_alloc_addr", 128'(alloc_addr), 128'h010);
    check("miss_wb_n", 128'(wb_n), 128'd0);
    check("miss_rdata", 128'(rd), 128'(mk_line(10'h010) & 128'hFFFFFFFF));

    acc(1'b0, 14'h0104, 4'h0, 32'h0);
    check("hit_stalls", 128'(stalls), 128'd0);
    check("hit_csn", 128'(csn_at_done), 128'd1);
    check("hit_rdata", 128'(rd), 128'h A5010010);

    acc(1'b1, 14'h0108, 4'hF, 32'hDEADBEEF);
    check("st1_stalls", 128'(stalls), 128'd0);
    acc(1'b1, 14'h0108, 4'h3, 32'h12345678);
    check("st2_stalls", 128'(stalls), 128'd0);
    acc(1'b0, 14'h0108, 4'h0, 32'h0);
    check("merge_stalls", 128'(stalls), 128'd0);
    check("merge_rdata", 128'(rd), 128'hDEAD5678);

    acc(1'b0, 14'h0180, 4'h0, 32'h0);
    check("dmiss_stalls", 128'(stalls), 128'd9);
    check("dmiss_wb_n", 128'(wb_n), 128'd4);
    check("dmiss_wb_addr", 128'(wb_addr), 128'h010);
    check("dmiss_wb_w2", 128'(wb_w2), 128'hDEAD5678);
    check("dmiss_alloc_n", 128'(alloc_n), 128'd4);
    check("dmiss_alloc_addr", 128'(alloc_addr), 128'h018);
    check("dmiss_rdata", 128'(rd), 128'hA5000018);

    acc(1'b0, 14'h0108, 4'h0, 32'h0);
    check("cmiss_stalls", 128'(stalls), 128'd5);
    check("cmiss_wb_n", 128'(wb_n), 128'd0);
    check("cmiss_rdata", 128'(rd), 128'hDEAD5678);

    bus.REQ = 1'b1; bus.WE = 1'b0; bus.ADDR = 14'h0200;
    @(negedge clk);
    check("rmid_miss_stall", 128'(bus.STALL), 128'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0; bus.REQ = 1'b0;
    @(negedge clk);
    check("rmid_stall_low", 128'(bus.STALL), 128'd0);
    check("rmid_rdata_low", 128'(bus.RDATA), 128'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rmid_csn", 128'(bus.D_MEM_CSN), 128'd1);
    check("rmid_stall", 128'(bus.STALL), 128'd0);
    csn_low = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!bus.D_MEM_CSN) csn_low++;
    end
    check("rmid_abandon", 128'(csn_low), 128'd0);
    @(posedge clk); #1;

    acc(1'b0, 14'h0100, 4'h0, 32'h0);
    check("post_rst_stalls", 128'(stalls), 128'd5);
    check("post_rst_rdata", 128'(rd), 128'hA5000010);
    acc(1'b0, 14'h0108, 4'h0, 32'h0);
    check("post_rst_hit", 128'(stalls), 128'd0);
    check("post_rst_wbdata", 128'(rd), 128'hDEAD5678);
    acc(1'b1, 14'h0104, 4'hF, 32'h11111111);
    check("post_rst_st", 128'(stalls), 128'd0);
    acc(1'b0, 14'h0180, 4'h0, 32'h0);
    check("post_rst_dmiss", 128'(stalls), 128'd9);
    check("post_rst_dmiss_wb", 128'(wb_n), 128'd4);
`ifdef RISCV_DCACHE_STAT_EN
    check("stat_hit", 128'(hit_cnt), 128'd2);
    check("stat_miss", 128'(miss_cnt), 128'd2);
`endif

    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("final_rst_csn", 128'(bus.D_MEM_CSN), 128'd1);
`ifdef RISCV_DCACHE_STAT_EN
    check("stat_hit_rst", 128'(hit_cnt), 128'd0);
    check("stat_miss_rst", 128'(miss_cnt), 128'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
